// File: rtl/mem_wr_splitter.sv
// mem_wr_splitter: splits one WB_DW-wide masked write into WB_DW/MEM_DW memory beats; reads pass through.
//   clk, rst                      clock and synchronous active-high reset
//   s_we_i, s_adr_i               bus command direction and word address
//   s_cmd_valid_i/s_cmd_ready_o   bus command handshake (write acked after its last beat)
//   s_data_i, s_sel_i             bus write data and byte enables
//   s_data_valid_i/s_data_ready_o bus write data handshake (single-cycle capture)
//   m_we_o, m_adr_o               beat direction and memory word address {base, lane}
//   m_cmd_valid_o/m_cmd_ready_i   memory command handshake
//   m_data_o, m_sel_o             beat data and byte enables
//   m_data_valid_o/m_data_ready_i memory data handshake (writes only)
module mem_wr_splitter #(
    parameter int WB_DW      = 32,
    parameter int MEM_DW     = 16,
    parameter int AW         = 32,
    parameter int SKIP_EMPTY = 0,
    localparam int SCALE     = WB_DW / MEM_DW,
    localparam int SW        = $clog2(SCALE),
    localparam int MSW       = MEM_DW / 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_we_i,
    input  logic [AW-1:0]      s_adr_i,
    input  logic               s_cmd_valid_i,
    output logic               s_cmd_ready_o,
    input  logic [WB_DW-1:0]   s_data_i,
    input  logic [WB_DW/8-1:0] s_sel_i,
    input  logic               s_data_valid_i,
    output logic               s_data_ready_o,
    output logic               m_we_o,
    output logic [AW+SW-1:0]   m_adr_o,
    output logic               m_cmd_valid_o,
    input  logic               m_cmd_ready_i,
    output logic [MEM_DW-1:0]  m_data_o,
    output logic [MSW-1:0]     m_sel_o,
    output logic               m_data_valid_o,
    input  logic               m_data_ready_i
);
    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;
    state_t             state_q, state_d;
    logic [SW-1:0]      lane_q, lane_d;
    logic [AW-1:0]      adr_q, adr_d;
    logic [WB_DW-1:0]   data_q, data_d;
    logic [WB_DW/8-1:0] sel_q, sel_d;
    logic [MSW-1:0]     beat_sel;
    logic               beat_live;
    logic               beat_done;

    assign beat_sel  = sel_q[lane_q*MSW +: MSW];
    assign m_data_o  = data_q[lane_q*MEM_DW +: MEM_DW];
    assign m_sel_o   = beat_sel;
    // a fully-masked lane is dropped only when skipping is enabled; it still spends one cycle
    assign beat_live = !(SKIP_EMPTY != 0 && beat_sel == '0);
    assign beat_done = !beat_live || (m_cmd_ready_i && m_data_ready_i);

    always_comb begin
        state_d        = state_q;
        lane_d         = lane_q;
        adr_d          = adr_q;
        data_d         = data_q;
        sel_d          = sel_q;
        s_cmd_ready_o  = 1'b0;
        s_data_ready_o = 1'b0;
        m_we_o         = 1'b0;
        m_adr_o        = {adr_q, lane_q};
        m_cmd_valid_o  = 1'b0;
        m_data_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_cmd_valid_i && !s_we_i) begin
                    m_cmd_valid_o = 1'b1;
                    m_adr_o       = {s_adr_i, {SW{1'b0}}};
                    s_cmd_ready_o = m_cmd_ready_i;
                end else if (s_cmd_valid_i && s_data_valid_i) begin
                    s_data_ready_o = 1'b1;
                    adr_d          = s_adr_i;
                    data_d         = s_data_i;
                    sel_d          = s_sel_i;
                    lane_d         = '0;
                    state_d        = BEAT;
                end
            end
            BEAT: begin
                m_we_o         = 1'b1;
                m_cmd_valid_o  = beat_live;
                m_data_valid_o = beat_live;
                if (beat_done) begin
                    if (lane_q == SW'(SCALE - 1)) state_d = DONE;
                    else lane_d = lane_q + SW'(1);
                end
            end
            DONE: begin
                s_cmd_ready_o = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // handshake outputs stay quiet for the whole reset cycle, not only after it
        if (rst) begin
            s_cmd_ready_o  = 1'b0;
            s_data_ready_o = 1'b0;
            m_cmd_valid_o  = 1'b0;
            m_data_valid_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
        end
    end

    always_ff @(posedge clk) begin
        adr_q  <= adr_d;
        data_q <= data_d;
        sel_q  <= sel_d;
    end
endmodule
